// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Execute-stage ALU with a start/done handshake. Single-cycle ops finish one
//   cycle after acceptance. Shifts with a non-zero amount iterate SHIFT_STEP
//   bits per cycle. Optional MUL / DIVU / REMU iterate one bit per cycle.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high; aborts any op in flight
//   start      request, accepted only while busy == 0
//   operation  4-bit opcode, sampled with start
//   x, y       WIDTH-bit operands, sampled with start
//   busy       1 while an iterative op is running
//   done       single-cycle pulse; result is valid from this cycle on
//   result     registered result; holds until the next done
module alu_multicycle #(
  parameter int WIDTH         = 32,
  parameter int SHIFT_STEP    = 1,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int SHW = $clog2(WIDTH);
  // One extra bit so the counter can hold WIDTH itself.
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] STEP_AMT = CW'(SHIFT_STEP);
  localparam logic [CW-1:0] FULL_CNT = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_SLTU = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SLL2 = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;
  localparam logic [3:0] OP_DIVU = 4'hC;
  localparam logic [3:0] OP_REMU = 4'hD;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;

  logic [3:0]       op_reg;
  // a_reg: shift value / multiplicand / dividend-then-quotient
  // b_reg: multiplier / divisor
  // acc_reg: product / partial remainder
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    step_amt;
  logic [CW-1:0]    shift_amt;
  logic             done_reg;
  logic [WIDTH-1:0] result_reg;

  logic             accept;
  logic [SHW-1:0]   shamt;
  logic             in_is_shift;
  logic             in_is_muldiv;
  logic             in_multi;
  logic [WIDTH-1:0] alu_value;
  logic             last_step;
  logic [WIDTH-1:0] run_result;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign accept       = start && (state_reg == IDLE);
  assign shamt        = y[SHW-1:0];
  assign in_is_shift  = operation inside {OP_SRL, OP_SRA, OP_SLL, OP_SLL2};
  assign in_is_muldiv = ENABLE_MULDIV && (operation inside {OP_MUL, OP_DIVU, OP_REMU});
  // Zero-amount shifts complete in a single cycle like the plain ALU ops.
  assign in_multi     = (in_is_shift && (shamt != '0)) || in_is_muldiv;

  // Single-cycle result, computed straight from the request inputs.
  always_comb begin
    alu_value = '0;
    case (operation)
      OP_ADD:  alu_value = x + y;
      OP_SUB:  alu_value = x - y;
      OP_OR:   alu_value = x | y;
      OP_XOR:  alu_value = x ^ y;
      OP_AND:  alu_value = x & y;
      OP_SLTU: alu_value = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      // Only reached with shamt == 0: the value passes through unchanged.
      OP_SRL, OP_SRA, OP_SLL, OP_SLL2: alu_value = x;
      // Undefined opcodes, and MUL/DIVU/REMU when they are not built.
      default: alu_value = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath step
  // ---------------------------------------------------------------------------
  assign shift_amt = (cnt_reg > STEP_AMT) ? STEP_AMT : cnt_reg;

  always_comb begin
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    step_amt   = ONE_CNT;
    rem_shift  = '0;
    rem_diff   = '0;
    run_result = '0;
    case (op_reg)
      OP_SRL: begin
        step_amt   = shift_amt;
        a_next     = a_reg >> shift_amt;
        run_result = a_next;
      end
      OP_SRA: begin
        // The sign bit stays put, so the fill is always the latched x MSB.
        step_amt   = shift_amt;
        a_next     = $unsigned($signed(a_reg) >>> shift_amt);
        run_result = a_next;
      end
      OP_SLL, OP_SLL2: begin
        step_amt   = shift_amt;
        a_next     = a_reg << shift_amt;
        run_result = a_next;
      end
      OP_MUL: begin
        acc_next   = acc_reg + (b_reg[0] ? a_reg : '0);
        a_next     = a_reg << 1;
        b_next     = b_reg >> 1;
        run_result = acc_next;
      end
      OP_DIVU, OP_REMU: begin
        // Restoring division: bring down the next dividend bit, try to
        // subtract the divisor, keep the difference if it did not go negative.
        // A zero divisor always "succeeds", giving all-ones and remainder x.
        rem_shift = {acc_reg, a_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_reg};
        if (!rem_diff[WIDTH]) begin
          acc_next = rem_diff[WIDTH-1:0];
          a_next   = {a_reg[WIDTH-2:0], 1'b1};
        end else begin
          acc_next = rem_shift[WIDTH-1:0];
          a_next   = {a_reg[WIDTH-2:0], 1'b0};
        end
        run_result = (op_reg == OP_DIVU) ? a_next : acc_next;
      end
      default: ;
    endcase
  end

  assign last_step = (cnt_reg == step_amt);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && in_multi) state_next = RUN;
      RUN:     if (last_step)          state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == RUN);
  end

  // ---------------------------------------------------------------------------
  // Operand / result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg == IDLE) begin
        if (accept) begin
          op_reg <= operation;
          if (in_multi) begin
            a_reg   <= x;
            b_reg   <= y;
            acc_reg <= '0;
            cnt_reg <= in_is_shift ? {1'b0, shamt} : FULL_CNT;
          end else begin
            result_reg <= alu_value;
            done_reg   <= 1'b1;
          end
        end
      end else begin
        a_reg   <= a_next;
        b_reg   <= b_next;
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg - step_amt;
        if (last_step) begin
          result_reg <= run_result;
          done_reg   <= 1'b1;
        end
      end
    end
  end

  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start1, start8;
  logic [3:0]   operation;
  logic [W-1:0] x, y;
  logic         busy1, done1, busy8, done8;
  logic [W-1:0] result1, result8;

  logic         sel8;
  logic         busy_s, done_s;
  logic [W-1:0] result_s;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W), .SHIFT_STEP(1), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start1), .operation(operation),
    .x(x), .y(y), .busy(busy1), .done(done1), .result(result1)
  );

  alu_multicycle #(.WIDTH(W), .SHIFT_STEP(8), .ENABLE_MULDIV(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .operation(operation),
    .x(x), .y(y), .busy(busy8), .done(done8), .result(result8)
  );

  assign busy_s   = sel8 ? busy8   : busy1;
  assign done_s   = sel8 ? done8   : done1;
  assign result_s = sel8 ? result8 : result1;

  // ---------------------------------------------------------------------------
  // Reference model: results and latencies straight from the opcode rules
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W-1:0] r;
    int unsigned  sh;
    sh = b % W;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a | b;
      4'h3: r = a ^ b;
      4'h4: r = a & b;
      4'h5: r = (a < b) ? 1 : 0;
      4'h6: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'h7: r = a >> sh;
      4'h8: r = $unsigned($signed(a) >>> sh);
      4'h9, 4'hA: r = a << sh;
      4'hB: r = a * b;
      4'hC: r = (b == 0) ? {W{1'b1}} : a / b;
      4'hD: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b, input int step);
    int sh;
    sh = int'(b % W);
    if (op inside {4'h7, 4'h8, 4'h9, 4'hA}) return (sh == 0) ? 1 : (sh + step - 1) / step + 1;
    if (op inside {4'hB, 4'hC, 4'hD}) return W + 1;
    return 1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return {W{1'b1}};
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request into the selected DUT and measures what comes back.
  // lat == -1 means no done arrived within the cycle budget.
  task automatic run_op(input bit use8, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output logic [W-1:0] res,
                        output int busy_cnt, output bit pulse_ok);
    sel8      = use8;
    operation = op;
    x         = a;
    y         = b;
    if (use8) start8 = 1'b1;
    else      start1 = 1'b1;
    busy_cnt = 0;
    pulse_ok = 1'b0;
    res      = '0;
    tick();
    start1 = 1'b0;
    start8 = 1'b0;
    // Inputs may change freely after acceptance.
    operation = 4'($urandom);
    x         = W'($urandom);
    y         = W'($urandom);
    lat = 1;
    while (!done_s && lat < 100) begin
      if (busy_s) busy_cnt++;
      tick();
      lat++;
    end
    if (done_s) begin
      res = result_s;
      if (busy_s) busy_cnt++;
      tick();
      pulse_ok = !done_s && (result_s === res);
    end else begin
      lat = -1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed table
  // ---------------------------------------------------------------------------
  localparam int ND = 20;
  bit           d_s8  [ND] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1,0,0,0};
  logic [3:0]   d_op  [ND] = '{4'h0, 4'h1, 4'h6, 4'h5, 4'h4, 4'h2, 4'h3, 4'h8, 4'h7, 4'h7,
                               4'hB, 4'hC, 4'hD, 4'hC, 4'hD, 4'h9, 4'h8, 4'hA, 4'hE, 4'hF};
  logic [W-1:0] d_x   [ND] = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                               32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'h1, 32'h8000_0000, 32'h3, 32'h1234_5678, 32'hFFFF_FFFF};
  logic [W-1:0] d_y   [ND] = '{32'h1, 32'h1, 32'h1, 32'h1,
                               32'hFF00_FF00, 32'hFF00_FF00, 32'hFF00_FF00,
                               32'd31, 32'd31, 32'h20,
                               32'hFFFF_FFFF, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'd20, 32'd31, 32'd4, 32'h1, 32'h1};
  logic [W-1:0] d_res [ND] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h0,
                               32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
                               32'hFFFF_FFFF, 32'h1, 32'h8000_0000,
                               32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                               32'h0010_0000, 32'hFFFF_FFFF, 32'h30, 32'h0, 32'h0};
  int           d_lat [ND] = '{1, 1, 1, 1, 1, 1, 1, 32, 32, 1,
                               33, 33, 33, 33, 33, 4, 5, 5, 1, 1};

  task automatic test_reset();
    reset  = 1'b1;
    start1 = 1'b1;
    start8 = 1'b1;
    operation = 4'hB;
    x = 32'h1234_5678;
    y = 32'h9;
    tick();
    tick();
    tick();
    start1 = 1'b0;
    start8 = 1'b0;
    n_checks++;
    if ({busy1, done1, result1} !== {1'b0, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL reset_dut1: busy=%b done=%b result=%h, required 0 0 00000000", busy1, done1, result1);
    end
    n_checks++;
    if ({busy8, done8, result8} !== {1'b0, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL reset_dut8: busy=%b done=%b result=%h, required 0 0 00000000", busy8, done8, result8);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({busy1, done1, busy8, done8} !== 4'b0000) begin
      n_fails++;
      $display("FAIL reset_release: busy1=%b done1=%b busy8=%b done8=%b, required all 0", busy1, done1, busy8, done8);
    end
    $display("reset: busy1=%b done1=%b result1=%h busy8=%b done8=%b result8=%h", busy1, done1, result1, busy8, done8, result8);
  endtask

  task automatic test_directed();
    int lat, bcnt;
    logic [W-1:0] res;
    bit pulse_ok;
    for (int i = 0; i < ND; i++) begin
      run_op(d_s8[i], d_op[i], d_x[i], d_y[i], lat, res, bcnt, pulse_ok);
      $display("directed[%0d] step=%0d op=%h x=%h y=%h result=%h lat=%0d", i, d_s8[i] ? 8 : 1, d_op[i], d_x[i], d_y[i], res, lat);
      n_checks++;
      if (lat != d_lat[i]) begin
        n_fails++;
        $display("FAIL directed[%0d] latency: got %0d, required %0d", i, lat, d_lat[i]);
      end
      n_checks++;
      if (res !== d_res[i]) begin
        n_fails++;
        $display("FAIL directed[%0d] result: got %h, required %h", i, res, d_res[i]);
      end
      n_checks++;
      if (bcnt != d_lat[i] - 1) begin
        n_fails++;
        $display("FAIL directed[%0d] busy_cycles: got %0d, required %0d", i, bcnt, d_lat[i] - 1);
      end
      n_checks++;
      if (!pulse_ok) begin
        n_fails++;
        $display("FAIL directed[%0d] done_pulse: done not a single pulse or result did not hold", i);
      end
    end
  endtask

  task automatic test_random();
    int lat, bcnt, exp_lat;
    logic [W-1:0] res, a, b, exp_res;
    logic [3:0] op;
    bit pulse_ok, use8;
    for (int i = 0; i < 60; i++) begin
      use8 = (i >= 40);
      op = 4'($urandom_range(0, 15));
      a  = rand_word();
      b  = rand_word();
      if (op inside {4'h7, 4'h8, 4'h9, 4'hA} && $urandom_range(0, 1) == 1) b = W'($urandom);
      exp_res = ref_result(op, a, b);
      exp_lat = ref_latency(op, b, use8 ? 8 : 1);
      run_op(use8, op, a, b, lat, res, bcnt, pulse_ok);
      $display("random[%0d] step=%0d op=%h x=%h y=%h result=%h lat=%0d", i, use8 ? 8 : 1, op, a, b, res, lat);
      n_checks++;
      if (res !== exp_res || lat != exp_lat) begin
        n_fails++;
        $display("FAIL random[%0d] op=%h: result=%h lat=%0d, required %h lat=%0d", i, op, res, lat, exp_res, exp_lat);
      end
      n_checks++;
      if (bcnt != exp_lat - 1 || !pulse_ok) begin
        n_fails++;
        $display("FAIL random[%0d] handshake: busy_cycles=%0d pulse_ok=%b, required %0d 1", i, bcnt, pulse_ok, exp_lat - 1);
      end
    end
  endtask

  // DIVU followed by ADD 1,1 requested every cycle while busy.
  task automatic test_back_to_back();
    logic [W-1:0] a, b, q;
    int cyc, extra_done;
    sel8 = 1'b0;
    a = W'($urandom);
    b = W'($urandom_range(1, 1000));
    q = a / b;
    operation = 4'hC;
    x = a;
    y = b;
    start1 = 1'b1;
    tick();
    operation = 4'h0;
    x = 32'h1;
    y = 32'h1;
    cyc = 1;
    extra_done = 0;
    while (!done1 && cyc < 100) begin
      tick();
      cyc++;
    end
    $display("back_to_back: divu x=%h y=%h result=%h lat=%0d", a, b, result1, cyc);
    n_checks++;
    if (!done1 || cyc != W + 1 || result1 !== q || busy1 !== 1'b0) begin
      n_fails++;
      $display("FAIL back_to_back divu: done=%b lat=%0d result=%h busy=%b, required 1 %0d %h 0", done1, cyc, result1, busy1, W + 1, q);
    end
    // start is still high in the done cycle, so the ADD is taken at this edge.
    tick();
    start1 = 1'b0;
    $display("back_to_back: add 1,1 done=%b result=%h", done1, result1);
    n_checks++;
    if (done1 !== 1'b1 || result1 !== 32'h2) begin
      n_fails++;
      $display("FAIL back_to_back add: done=%b result=%h, required 1 00000002", done1, result1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done1 !== 1'b0) extra_done++;
    end
    n_checks++;
    if (extra_done != 0 || result1 !== 32'h2) begin
      n_fails++;
      $display("FAIL back_to_back tail: extra dones=%0d result=%h, required 0 00000002", extra_done, result1);
    end
  endtask

  // Reset part-way through MUL: no done for it, result cleared, then normal use.
  task automatic test_reset_abort();
    int cyc, stray, lat, bcnt;
    logic [W-1:0] res, a, b;
    bit pulse_ok;
    sel8 = 1'b0;
    operation = 4'hB;
    x = W'($urandom) | 32'h1;
    y = W'($urandom) | 32'h1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 1;
    stray = 0;
    while (cyc < 10) begin
      if (done1) stray++;
      tick();
      cyc++;
    end
    n_checks++;
    if (busy1 !== 1'b1 || stray != 0) begin
      n_fails++;
      $display("FAIL abort_pre: busy=%b early dones=%0d, required 1 0", busy1, stray);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("abort: after reset busy=%b done=%b result=%h", busy1, done1, result1);
    n_checks++;
    if ({busy1, done1, result1} !== {1'b0, 1'b0, 32'h0}) begin
      n_fails++;
      $display("FAIL abort_reset: busy=%b done=%b result=%h, required 0 0 00000000", busy1, done1, result1);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done1 !== 1'b0 || busy1 !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fails++;
      $display("FAIL abort_quiet: %0d cycles with done/busy after abort, required 0", stray);
    end
    a = W'($urandom);
    b = W'($urandom);
    run_op(1'b0, 4'h0, a, b, lat, res, bcnt, pulse_ok);
    $display("abort: follow-up add x=%h y=%h result=%h lat=%0d", a, b, res, lat);
    n_checks++;
    if (res !== a + b || lat != 1 || !pulse_ok) begin
      n_fails++;
      $display("FAIL abort_followup: result=%h lat=%0d pulse_ok=%b, required %h 1 1", res, lat, pulse_ok, a + b);
    end
  endtask

  initial begin
    reset = 1'b0;
    start1 = 1'b0;
    start8 = 1'b0;
    sel8 = 1'b0;
    operation = '0;
    x = '0;
    y = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
